// File: rtl/quad_signal_gen.sv
// Quadrature A/B generator: plays "move N detents" commands as Gray-coded steps, P clocks per transition.
// Registered outputs change on the step edge; cmd_ready is low for the whole command and valid is ignored meanwhile.
module quad_signal_gen #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [WIDTH-1:0]     cmd_steps,
  input  logic [DIV_WIDTH-1:0] cmd_period,
  input  logic                 abort,
  output logic                 a,
  output logic                 b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     remaining
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;
  localparam logic [WIDTH-1:0]     REM_ONE = 1;

  state_t               state;
  logic                 dir_q;
  logic [DIV_WIDTH-1:0] period_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 half_q;
  logic                 abort_pend_q;
  logic [1:0]           p_q;
  logic [1:0]           p_next;
  logic                 step;
  logic [WIDTH-1:0]     rem_dec;

  assign step      = (div_q == period_q - DIV_ONE);
  assign p_next    = dir_q ? p_q + 2'd1 : p_q - 2'd1;
  assign rem_dec   = remaining - REM_ONE;
  assign busy      = (state == RUN);
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dir_q        <= 1'b0;
      period_q     <= DIV_ONE;
      div_q        <= '0;
      half_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      p_q          <= 2'd0;
      a            <= 1'b0;
      b            <= 1'b0;
      done         <= 1'b0;
      remaining    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir_q        <= cmd_dir;
            period_q     <= (cmd_period == '0) ? DIV_ONE : cmd_period;
            remaining    <= cmd_steps;
            div_q        <= '0;
            half_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            if (cmd_steps == '0) done  <= 1'b1;
            else                 state <= RUN;
          end
        end
        RUN: begin
          if (step) begin
            // Phase 0=00, 1=10, 2=11, 3=01 as {a,b}.
            p_q    <= p_next;
            a      <= p_next[1] ^ p_next[0];
            b      <= p_next[1];
            div_q  <= '0;
            half_q <= ~half_q;
            if (half_q) begin
              if (rem_dec == '0 || abort || abort_pend_q) begin
                state        <= IDLE;
                done         <= 1'b1;
                remaining    <= '0;
                abort_pend_q <= 1'b0;
              end else begin
                remaining <= rem_dec;
              end
            end else if (abort) begin
              abort_pend_q <= 1'b1;
            end
          end else begin
            div_q <= div_q + DIV_ONE;
            if (abort) begin
              if (!half_q) begin
                state     <= IDLE;
                done      <= 1'b1;
                remaining <= '0;
              end else begin
                abort_pend_q <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_signal_gen.sv
// Bench for quad_signal_gen: elapsed-time model checked every cycle plus directed literal checks.
module tb_quad_signal_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [7:0]  cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        a, b, busy, done;
  logic [7:0]  remaining;

  quad_signal_gen #(.WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .a(a), .b(b), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time since accept fixes transitions (t/P) and detents (t/2P); abort moves the stop time.
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int m_t = 0, m_stop = 0, m_n = 0, m_per = 1, m_p0 = 0, m_p = 0, m_rem = 0;
  bit m_busy = 1'b0, m_done = 1'b0, m_dir = 1'b0;
  int m_nt, m_ns, m_tr;

  function automatic int per_of(input logic [15:0] p);
    return (p == 0) ? 1 : int'(p);
  endfunction

  function automatic int abort_stop(input int t, input int stop, input int per);
    int tr, cand;
    tr = t / per;
    if ((t % per) != 0 && (tr % 2) == 0) cand = t;
    else cand = ((tr + 1) / 2) * 2 * per;
    return (cand < stop) ? cand : stop;
  endfunction

  assign m_nt = m_t + 1;
  assign m_ns = (abort && m_nt < m_stop) ? abort_stop(m_nt, m_stop, m_per) : m_stop;
  assign m_tr = m_nt / m_per;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_rem <= 0; m_p <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (cmd_valid) begin
        m_rem <= int'(cmd_steps);
        if (cmd_steps == 0) m_done <= 1'b1;
        else begin
          m_busy <= 1'b1; m_t <= 0; m_n <= int'(cmd_steps);
          m_per <= per_of(cmd_period);
          m_stop <= 2 * int'(cmd_steps) * per_of(cmd_period);
          m_dir <= cmd_dir; m_p0 <= m_p;
        end
      end
    end else begin
      m_t    <= m_nt;
      m_stop <= m_ns;
      m_p    <= m_dir ? ((m_p0 + m_tr) & 3) : ((m_p0 - m_tr) & 3);
      m_rem  <= (m_nt == m_ns) ? 0 : m_n - m_tr / 2;
      m_busy <= (m_nt < m_ns);
      m_done <= (m_nt == m_ns);
    end
  end

  // Encoder stand-in: one count per detent, on arrival at an even phase.
  logic [7:0] enc = '0;
  logic [1:0] prev_ab = 2'b00;

  function automatic int ph(input logic [1:0] ab);
    case (ab)
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ab", {a, b}, ab_tab[m_p]);
      check("model_busy", busy, m_busy);
      check("model_ready", cmd_ready, !m_busy);
      check("model_done", done, m_done);
      check("model_rem", remaining, m_rem);
      if (ph({a, b}) % 2 == 0 && ph(prev_ab) % 2 == 1) begin
        if (((ph({a, b}) - ph(prev_ab)) & 3) == 1) enc <= enc + 8'd1;
        else enc <= enc - 8'd1;
      end
      prev_ab <= {a, b};
    end
  end

  task automatic send(input logic d, input int n, input int per);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = d; cmd_steps = n[7:0]; cmd_period = per[15:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_busy", busy, n != 0);
  endtask

  task automatic wait_done(input string name, input int exp_k, input int max);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < max);
    check(name, k, exp_k);
  endtask

  task automatic check_enc(input string name, input logic [7:0] base, input logic [7:0] start,
                           input logic [7:0] exp);
    logic [7:0] v;
    #2;
    v = start + (enc - base);
    check(name, v, exp);
  endtask

  logic [1:0] seq_up [6] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
  logic [1:0] seq_dn [6] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
  logic [7:0] e0;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ab", {a, b}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rem", remaining, 8'd0);
    check("rst_ready", cmd_ready, 1'b1);
    reset = 1'b0;

    // Up 3 detents at P=4.
    e0 = enc;
    send(1'b1, 3, 4);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k % 4 == 0) check("up3_ab", {a, b}, seq_up[k / 4 - 1]);
    end
    check("up3_done", done, 1'b1);
    check_enc("up3_enc", e0, 8'd0, 8'd3);

    // Down 3 detents at P=1 from rest 11.
    e0 = enc;
    send(1'b0, 3, 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("dn3_ab", {a, b}, seq_dn[k - 1]);
    end
    check("dn3_done", done, 1'b1);
    check_enc("dn3_enc", e0, 8'd3, 8'd0);

    // 200 detents up from a count of 250 wraps to 194.
    e0 = enc;
    send(1'b1, 200, 1);
    wait_done("wrap_done_k", 400, 500);
    check("wrap_rem", remaining, 8'd0);
    check_enc("wrap_enc", e0, 8'd250, 8'd194);

    // Abort mid-detent: sampled at T+3, detent finishes at T+4.
    e0 = enc;
    send(1'b1, 10, 2);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abm_rem_mid", remaining, 8'd10);
    wait_done("abm_done_k", 1, 20);
    check("abm_rem", remaining, 8'd0);
    check_enc("abm_enc", e0, 8'd0, 8'd1);

    // Abort at rest: sampled at T+5, stop on that edge.
    e0 = enc;
    send(1'b1, 10, 2);
    repeat (4) @(negedge clk);
    check("abr_rem_mid", remaining, 8'd9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abr_done", done, 1'b1);
    repeat (4) @(negedge clk);
    check_enc("abr_enc", e0, 8'd0, 8'd1);

    // Valid held through the command, with different fields, is not relatched.
    e0 = enc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd2; cmd_period = 16'd1;
    @(negedge clk);
    cmd_steps = 8'd7; cmd_dir = 1'b0;
    wait_done("hold_done_k", 4, 20);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("hold_idle", busy, 1'b0);
    check_enc("hold_enc", e0, 8'd0, 8'd2);

    // Zero steps: immediate done, no motion.
    send(1'b0, 0, 5);
    check("zero_done", done, 1'b1);
    check("zero_ab", {a, b}, 2'b00);
    @(negedge clk);
    check("zero_done_off", done, 1'b0);

    // Period 0 runs as P=1.
    send(1'b1, 1, 0);
    wait_done("p0_done_k", 2, 10);
    check("p0_ab", {a, b}, 2'b11);

    // Reset in the middle of a command.
    send(1'b1, 4, 2);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_ab", {a, b}, 2'b00);
    check("mrst_busy", busy, 1'b0);
    check("mrst_rem", remaining, 8'd0);
    check("mrst_ready", cmd_ready, 1'b1);
    send(1'b1, 1, 1);
    @(negedge clk);
    check("post_ab1", {a, b}, 2'b10);
    @(negedge clk);
    check("post_ab2", {a, b}, 2'b11);
    check("post_done", done, 1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
